skid_register: RTL

- Full-throughput valid/ready pipeline slice: one registered stage with a one-entry skid buffer, so back-pressure never costs a bubble.
- Fills the gap the plain free-running register leaves: it is the receive/forward end of a flow-controlled link, accepting words upstream and presenting them downstream.
- Used to break long valid/ready/data timing paths between blocks.

---
 rtl/skid_register_pkg.sv | 20 ++
 rtl/skid_register.sv | 90 +++++++++
 2 files changed

// File: rtl/skid_register_pkg.sv
// ----------------------------------------------------------------------------
// skid_register_pkg : state encoding and widths shared by the skid slice
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package skid_register_pkg;

  localparam int OCC_WIDTH = 2;

  // Encoded so that the state value is the number of words held.
  typedef enum logic [OCC_WIDTH-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/skid_register.sv
// ----------------------------------------------------------------------------
// skid_register : registered valid/ready slice with a one-entry skid buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module skid_register
  import skid_register_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [OCC_WIDTH-1:0]  OCCUPANCY
);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    s_ready_q;
  logic                    m_valid_q;
  logic                    up_xfer;
  logic                    down_xfer;

  assign up_xfer   = S_VALID & s_ready_q;
  assign down_xfer = m_valid_q & M_READY;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          data_d  = S_DATA;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && down_xfer) begin
          data_d = S_DATA;
        end else if (up_xfer) begin
          skid_d  = S_DATA;
          state_d = FULL;
        end else if (down_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // S_READY is low here, so only the skid word can move.
        if (down_xfer) begin
          data_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are precomputed from the next state so they come from flops.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d != EMPTY);
    end
  end

  assign S_READY   = s_ready_q;
  assign M_VALID   = m_valid_q;
  assign M_DATA    = data_q;
  assign OCCUPANCY = state_q;

endmodule

`default_nettype wire
